chunk_stream_loader: RTL

//  Parses the chunk byte stream from uart_receive into addressed block writes for l3_cache.

---
 rtl/chunk_stream_loader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/chunk_stream_loader.sv
// chunk_stream_loader: turns the UART chunk byte stream (header, payload, XOR
// checksum) into addressed block writes for the cache, and keeps sticky frame
// status flags that downstream init logic gates on.
module chunk_stream_loader #(
    parameter int         LENGTH         = 64,
    parameter int         WIDTH          = 64,
    parameter int         HEIGHT         = 16,
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100_000
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid_in,
    input  logic                      wr_ready_in,
    output logic                      wr_valid_out,
    output logic [$clog2(LENGTH)-1:0] wr_x_out,
    output logic [$clog2(HEIGHT)-1:0] wr_y_out,
    output logic [$clog2(WIDTH)-1:0]  wr_z_out,
    output logic [7:0]                wr_block_out,
    output logic                      busy_out,
    output logic                      done_out,
    output logic                      loaded_out,
    output logic                      crc_err_out,
    output logic                      overrun_err_out,
    output logic                      timeout_err_out
);

    localparam int XW = $clog2(LENGTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int ZW = $clog2(WIDTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [XW-1:0] X_MAX      = XW'(LENGTH - 1);
    localparam logic [YW-1:0] Y_MAX      = YW'(HEIGHT - 1);
    localparam logic [ZW-1:0] Z_MAX      = ZW'(WIDTH - 1);
    localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [ZW-1:0] z_q;
    logic [7:0]    sum_q;
    logic [TW-1:0] idle_q;

    logic in_frame;
    logic stall;
    logic take;
    logic overrun;
    logic timeout_hit;
    logic start;
    logic last_pos;

    // A byte can only be taken when no write is stuck waiting on the cache;
    // a byte that arrives during such a stall is an overrun and aborts the frame.
    assign in_frame    = (state_q != IDLE);
    assign stall       = wr_valid_out && !wr_ready_in;
    assign take        = in_frame && byte_valid_in && !stall;
    assign overrun     = in_frame && byte_valid_in && stall;
    assign timeout_hit = in_frame && !byte_valid_in && (idle_q == IDLE_LIMIT);
    assign start       = (state_q == IDLE) && byte_valid_in && (byte_in == HEADER);
    assign last_pos    = (x_q == X_MAX) && (y_q == Y_MAX) && (z_q == Z_MAX);
    assign busy_out    = in_frame;

    // State register.
    // NOTE: every register is cleared by the asynchronous reset so a mid-frame
    // reset leaves no partial address, checksum or flag behind.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state_q <= state_d;
        end
    end

    // Next-state logic: header starts a frame, last payload byte moves to
    // CHECK, checksum byte or any abort returns to IDLE.
    always_comb begin
        // NOTE: default first so no path through the case infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = PAYLOAD;
            end
            PAYLOAD: begin
                if (overrun || timeout_hit) state_d = IDLE;
                else if (take && last_pos)  state_d = CHECK;
            end
            CHECK: begin
                if (overrun || timeout_hit || take) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Write channel: present each payload byte one cycle after it is taken,
    // hold it while the cache stalls, drop valid after the handshake.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_valid_out <= 1'b0;
            wr_x_out     <= '0;
            wr_y_out     <= '0;
            wr_z_out     <= '0;
            wr_block_out <= '0;
        end else if (state_q == PAYLOAD && take) begin
            wr_valid_out <= 1'b1;
            wr_x_out     <= x_q;
            wr_y_out     <= y_q;
            wr_z_out     <= z_q;
            wr_block_out <= byte_in;
        end else if (wr_ready_in) begin
            wr_valid_out <= 1'b0;
        end
    end

    // Address walk (x fastest, then z, then y) and running payload checksum.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            sum_q <= '0;
        end else if (start) begin
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            sum_q <= '0;
        end else if (state_q == PAYLOAD && take) begin
            sum_q <= sum_q ^ byte_in;
            if (x_q != X_MAX) begin
                x_q <= x_q + 1'b1;
            end else begin
                x_q <= '0;
                if (z_q != Z_MAX) begin
                    z_q <= z_q + 1'b1;
                end else begin
                    z_q <= '0;
                    y_q <= y_q + 1'b1;
                end
            end
        end
    end

    // Inter-byte idle counter; restarts on every byte while a frame is open.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            idle_q <= '0;
        end else if (start || (in_frame && byte_valid_in)) begin
            idle_q <= '0;
        end else if (in_frame) begin
            idle_q <= idle_q + 1'b1;
        end
    end

    // Frame status: done pulse on the checksum byte, sticky result and error
    // flags, all cleared when the next header opens a frame.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            done_out        <= 1'b0;
            loaded_out      <= 1'b0;
            crc_err_out     <= 1'b0;
            overrun_err_out <= 1'b0;
            timeout_err_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            if (start) begin
                loaded_out      <= 1'b0;
                crc_err_out     <= 1'b0;
                overrun_err_out <= 1'b0;
                timeout_err_out <= 1'b0;
            end else begin
                if (overrun)     overrun_err_out <= 1'b1;
                if (timeout_hit) timeout_err_out <= 1'b1;
                if (state_q == CHECK && take) begin
                    done_out <= 1'b1;
                    if (byte_in == sum_q) loaded_out  <= 1'b1;
                    else                  crc_err_out <= 1'b1;
                end
            end
        end
    end

endmodule
